// File: rtl/lisp_pkg.sv
// Shared constants and enums for the lisp machine datapath.
// This file adds the cell-RAM geometry, requester ids and arbiter states.
package lisp;

    localparam int data_width = 16;
    localparam int addr_width = 10;
    localparam int mem_depth  = 1024;

    // Object tag written as the first word of a cons cell.
    localparam logic [data_width-1:0] TYPE_CONS = 16'h0002;

    typedef enum logic [1:0] {
        REQ_EVAL  = 2'd0,
        REQ_ALLOC = 2'd1,
        REQ_DEBUG = 2'd2
    } req_idx_e;

    typedef enum logic {
        ArbIdle   = 1'b0,
        ArbLocked = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr,
// wrapping to the lowest requesting index overall.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [N_REQ-1:0] hi_req;

    for (genvar i = 0; i < N_REQ; i++) begin : g_hi
        assign hi_req[i] = req[i] && (32'(i) >= 32'(ptr));
    end

    // x & -x isolates the lowest set bit.
    assign winner = (|hi_req) ? (hi_req & (-hi_req)) : (req & (-req));
    assign valid  = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with atomic lock for the single-port cell RAM.
// Grants are combinational; read data returns one cycle after acceptance.
module mem_arbiter
    import lisp::*;
#(
    parameter int N_REQ     = 3,
    parameter int DATA_W    = data_width,
    parameter int ADDR_W    = addr_width,
    parameter int MEM_DEPTH = mem_depth,
    parameter int MAX_LOCK  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             we,
    input  logic [N_REQ-1:0]             lock,
    input  logic [N_REQ-1:0][ADDR_W-1:0] addr,
    input  logic [N_REQ-1:0][DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REQ-1:0]             rvalid,
    output logic [DATA_W-1:0]            rdata,
    output logic [N_REQ-1:0]             err,
    output logic                         ram_en,
    output logic                         ram_we,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [DATA_W-1:0]            ram_wdata,
    input  logic [DATA_W-1:0]            ram_rdata
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic [PTR_W-1:0] rd_idx_q, rd_idx_d;
    logic [N_REQ-1:0] err_q, err_d;

    logic [N_REQ-1:0] pick_gnt;
    logic             pick_valid;
    logic [PTR_W-1:0] win_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic             beat;
    logic             legal;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (32'(idx) == 32'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_pick #(
        .N_REQ(N_REQ),
        .PTR_W(PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .winner(pick_gnt),
        .valid (pick_valid)
    );

    // While locked, only the owner can be granted, even if it is idle.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (state_q == ArbLocked) begin
                gnt = req[owner_q] ? (N_REQ'(1) << owner_q) : '0;
            end else if (pick_valid) begin
                gnt = pick_gnt;
            end
        end
    end

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) win_idx = PTR_W'(i);
        end
    end

    assign beat     = |gnt;
    assign sel_addr = addr[win_idx];
    assign legal    = 32'(sel_addr) < 32'(MEM_DEPTH);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        err_d     = '0;
        rd_pend_d = beat && legal && !we[win_idx];
        rd_idx_d  = win_idx;
        ram_en    = beat && legal;
        ram_we    = beat && legal && we[win_idx];
        ram_addr  = sel_addr;
        ram_wdata = wdata[win_idx];

        if (beat && !legal) err_d[win_idx] = 1'b1;

        case (state_q)
            ArbIdle: begin
                if (beat) begin
                    ptr_d = next_ptr(win_idx);
                    if (lock[win_idx]) begin
                        state_d = ArbLocked;
                        owner_d = win_idx;
                        cnt_d   = '0;
                    end
                end
            end
            ArbLocked: begin
                cnt_d = cnt_q + 1'b1;
                // Timeout wins over any release the owner asks for this cycle.
                if (cnt_d == CNT_W'(MAX_LOCK)) begin
                    state_d        = ArbIdle;
                    err_d[owner_q] = 1'b1;
                    ptr_d          = next_ptr(owner_q);
                    cnt_d          = '0;
                end else if (!lock[owner_q] && (beat || !req[owner_q])) begin
                    state_d = ArbIdle;
                    ptr_d   = next_ptr(owner_q);
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ArbIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ArbIdle;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
            err_q     <= err_d;
        end
    end

    assign rvalid = rd_pend_q ? (N_REQ'(1) << rd_idx_q) : '0;
    assign rdata  = ram_rdata;
    assign err    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_mem_arbiter;
    import lisp::*;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 1000;
    localparam int MLOCK = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]         req, we, lock;
    logic [N-1:0][AW-1:0] addr;
    logic [N-1:0][DW-1:0] wdata;
    logic [N-1:0]         gnt, rvalid, err;
    logic [DW-1:0]        rdata;
    logic                 ram_en, ram_we;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_wdata;
    logic [DW-1:0]        ram_rdata;

    mem_arbiter #(
        .N_REQ    (N),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .MEM_DEPTH(DEPTH),
        .MAX_LOCK (MLOCK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .lock     (lock),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .err      (err),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Cell RAM: synchronous read, write at the accepting edge.
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model state: what the arbiter must remember, by its rules.
    logic [DW-1:0] shadow [1024];
    logic [DW-1:0] exp_q[$];
    int            exp_who_q[$];
    int            m_ptr, m_owner, m_held, m_w, m_idx, m_who;
    bit            m_locked, m_legal;
    logic [N-1:0]  m_err, m_next_err, e_gnt, e_rv;
    logic [DW-1:0] e_rd;
    logic [1:0]    w2, o2;

    always @(negedge clk) begin
        if (rst) begin
            m_ptr = 0; m_owner = 0; m_held = 0; m_locked = 0; m_err = '0;
            exp_q.delete();
            exp_who_q.delete();
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_rvalid", 32'(rvalid), 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_ram_en", 32'(ram_en), 0);
        end else begin
            m_w = -1;
            o2  = 2'(m_owner);
            if (m_locked) begin
                if (req[o2]) m_w = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    m_idx = (m_ptr + k) % N;
                    if (m_w < 0 && req[2'(m_idx)]) m_w = m_idx;
                end
            end
            w2 = 2'(m_w);
            e_gnt = '0;
            if (m_w >= 0) e_gnt[w2] = 1'b1;
            m_legal = (m_w >= 0) && (int'(addr[w2]) < DEPTH);

            e_rv = '0;
            e_rd = '0;
            if (exp_q.size() > 0) begin
                e_rd  = exp_q.pop_front();
                m_who = exp_who_q.pop_front();
                e_rv[2'(m_who)] = 1'b1;
            end

            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("rvalid", 32'(rvalid), 32'(e_rv));
            chk("err", 32'(err), 32'(m_err));
            chk("ram_en", 32'(ram_en), 32'(m_legal));
            chk("ram_we", 32'(ram_we), 32'(m_legal && we[w2]));
            if (m_legal) chk("ram_addr", 32'(ram_addr), 32'(addr[w2]));
            if (m_legal && we[w2]) chk("ram_wdata", 32'(ram_wdata), 32'(wdata[w2]));
            if (e_rv != '0) chk("rdata", 32'(rdata), 32'(e_rd));

            // Advance the model across the coming clock edge.
            m_next_err = '0;
            if (m_w >= 0) begin
                if (!m_legal) m_next_err[w2] = 1'b1;
                else if (we[w2]) shadow[addr[w2]] = wdata[w2];
                else begin
                    exp_q.push_back(shadow[addr[w2]]);
                    exp_who_q.push_back(m_w);
                end
            end
            if (m_locked) begin
                m_held++;
                if (m_held == MLOCK) begin
                    m_locked = 0;
                    m_next_err[o2] = 1'b1;
                    m_ptr = (m_owner + 1) % N;
                end else if (!lock[o2] && (m_w >= 0 || !req[o2])) begin
                    m_locked = 0;
                    m_ptr = (m_owner + 1) % N;
                end
            end else if (m_w >= 0) begin
                m_ptr = (m_w + 1) % N;
                if (lock[w2]) begin
                    m_locked = 1;
                    m_owner  = m_w;
                    m_held   = 0;
                end
            end
            m_err = m_next_err;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] l);
        req  = r;
        we   = w;
        lock = l;
    endtask

    logic [N-1:0]  rr_exp [6];
    logic [DW-1:0] cons_val [3];
    logic [N-1:0]  cons_lock [3];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 16'(i * 3 + 1);
            shadow[i] = 16'(i * 3 + 1);
        end
        mem[2]    = 16'h0012;
        shadow[2] = 16'h0012;
        rr_exp    = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        cons_val  = '{TYPE_CONS, 16'h0001, 16'h0009};
        cons_lock = '{3'b010, 3'b010, 3'b000};
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0;

        // Reset state with a request pending: no grant while in reset.
        req = 3'b001;
        @(negedge clk);
        chk("reset_gnt_lit", 32'(gnt), 0);
        chk("reset_ram_en_lit", 32'(ram_en), 0);
        next_cycle();
        rst = 1'b0;

        // Single read of RAM[2].
        drive(3'b001, 3'b000, 3'b000);
        addr[0] = 10'h002;
        @(negedge clk);
        chk("read_gnt_lit", 32'(gnt), 32'h1);
        chk("read_ram_en_lit", 32'(ram_en), 1);
        chk("read_ram_we_lit", 32'(ram_we), 0);
        next_cycle();
        drive(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        chk("read_rvalid_lit", 32'(rvalid), 32'h1);
        chk("read_rdata_lit", 32'(rdata), 32'h0012);

        // Round robin with everyone reading; pointer starts at 1 after the read above.
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            drive(3'b111, 3'b000, 3'b000);
            addr[0] = 10'(16 + k); addr[1] = 10'(48 + k); addr[2] = 10'(80 + k);
            @(negedge clk);
            chk("rr_gnt_lit", 32'(gnt), 32'(rr_exp[k]));
            if (k > 0) chk("rr_rvalid_lit", 32'(rvalid), 32'(rr_exp[k-1]));
        end
        next_cycle();
        drive(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        chk("rr_rvalid_last_lit", 32'(rvalid), 32'h1);

        // Locked cons write from the allocator while the evaluator keeps asking.
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(3'b011, 3'b010, cons_lock[k]);
            addr[REQ_EVAL]   = 10'h000;
            addr[REQ_ALLOC]  = 10'(32 + k);
            wdata[REQ_ALLOC] = cons_val[k];
            @(negedge clk);
            chk("cons_gnt_lit", 32'(gnt), 32'h2);
        end
        next_cycle();
        drive(3'b001, 3'b000, 3'b000);
        @(negedge clk);
        chk("cons_eval_gnt_lit", 32'(gnt), 32'h1);
        next_cycle();
        drive(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        chk("cons_ram20_lit", 32'(mem[10'h020]), 32'(TYPE_CONS));
        chk("cons_ram21_lit", 32'(mem[10'h021]), 32'h0001);
        chk("cons_ram22_lit", 32'(mem[10'h022]), 32'h0009);

        // Illegal address from the debug reader.
        next_cycle();
        drive(3'b100, 3'b000, 3'b000);
        addr[2] = 10'd1000;
        @(negedge clk);
        chk("illegal_gnt_lit", 32'(gnt), 32'h4);
        chk("illegal_ram_en_lit", 32'(ram_en), 0);
        next_cycle();
        drive(3'b000, 3'b000, 3'b000);
        @(negedge clk);
        chk("illegal_err_lit", 32'(err), 32'h4);
        chk("illegal_rvalid_lit", 32'(rvalid), 0);

        // Runaway lock: evaluator never releases, allocator waits.
        addr[0] = 10'h005; addr[1] = 10'h006;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            drive(3'b011, 3'b000, 3'b001);
            @(negedge clk);
            if (c < 5) begin
                chk("lock_gnt_lit", 32'(gnt), 32'h1);
                chk("lock_err_lit", 32'(err), 0);
            end else begin
                chk("timeout_err_lit", 32'(err), 32'h1);
                chk("timeout_gnt_lit", 32'(gnt), 32'h2);
            end
        end
        next_cycle();
        drive(3'b000, 3'b000, 3'b000);
        @(negedge clk);

        // Reset right after a read is accepted; pointer is 2 beforehand.
        next_cycle();
        drive(3'b010, 3'b000, 3'b000);
        @(negedge clk);
        chk("prereset_gnt_lit", 32'(gnt), 32'h2);
        next_cycle();
        rst = 1'b1;
        drive(3'b110, 3'b000, 3'b000);
        @(negedge clk);
        chk("inreset_gnt_lit", 32'(gnt), 0);
        chk("inreset_rvalid_lit", 32'(rvalid), 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("postreset_gnt_lit", 32'(gnt), 32'h2);
        chk("postreset_rvalid_lit", 32'(rvalid), 0);
        next_cycle();
        drive(3'b000, 3'b000, 3'b000);
        @(negedge clk);

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 600; c++) begin
            next_cycle();
            for (int i = 0; i < N; i++) begin
                req[i]   = ($urandom_range(0, 3) != 0);
                we[i]    = ($urandom_range(0, 2) == 0);
                lock[i]  = ($urandom_range(0, 3) == 0);
                addr[i]  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(DEPTH, 1023))
                                                       : 10'($urandom_range(0, DEPTH - 1));
                wdata[i] = 16'($urandom);
            end
        end
        next_cycle();
        drive(3'b000, 3'b000, 3'b000);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
